// File: rtl/alu_pkg.sv
// Shared types and sizes for the ALU sweep controller and its result bank.
package alu_pkg;

  localparam int ALU_DATA_W  = 8;
  localparam int ALU_SEL_W   = 4;
  localparam int ALU_NUM_OPS = 16;

  // ST_ prefix keeps the SETTLE state apart from the SETTLE parameter of the top.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/alu_result_bank.sv
// Register file of sweep results: async-reset entries, one write port,
// registered read port that returns pre-write contents on a same-address collision.
module alu_result_bank
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** SEL_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/alu_sweep_capture.sv
// Sweeps a latched operand set through every ALU opcode, captures each result
// into the bank and folds it into a rotate-XOR signature.
module alu_sweep_capture
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int SETTLE = 2
) (
  input  logic              alu_clk,
  input  logic              alu_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              op_cin,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_c_in,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_y,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] signature,
  input  logic [SEL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  sweep_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              cin_q, cin_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic              wr_en;

  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sel_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sel_q   <= sel_d;
      sig_q   <= sig_d;
    end
  end

  // Drive values and signature persist after FINISH until the next accepted start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sel_d   = sel_q;
    sig_d   = sig_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          cin_d   = op_cin;
          sel_d   = '0;
          sig_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ alu_y;
        if (sel_q == '1) begin
          state_d = ST_FINISH;
        end else begin
          sel_d   = sel_q + SEL_W'(1);
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy  = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    done  = (state_q == ST_FINISH);
    wr_en = (state_q == ST_CAPTURE);
  end

  alu_result_bank #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_bank (
    .clk     (alu_clk),
    .rst_n   (alu_rst_n),
    .wr_en   (wr_en),
    .wr_addr (sel_q),
    .wr_data (alu_y),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_c_in  = cin_q;
  assign alu_sel   = sel_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_alu_sweep_capture.sv
// Directed bench for alu_sweep_capture: a SETTLE=2 and a SETTLE=1 instance,
// each driving a registered ALU stub (y = a ^ sel, or a forced constant).
module tb_alu_sweep_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic       op_cin = 1'b0;
  logic [3:0] rd_addr = 4'h0;

  logic [7:0] a0, b0, y0, sig0, rd0;
  logic [3:0] sel0;
  logic       cin0, busy0, done0;
  logic [7:0] a1, b1, y1, sig1, rd1;
  logic [3:0] sel1;
  logic       cin1, busy1, done1;

  logic       force0 = 1'b0;
  logic [7:0] cst0 = 8'h00;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0 <= 8'h00;
      y1 <= 8'h00;
    end else begin
      y0 <= force0 ? cst0 : (a0 ^ {4'b0, sel0});
      y1 <= a1 ^ {4'b0, sel1};
    end
  end

  alu_sweep_capture #(.DATA_W(8), .SEL_W(4), .SETTLE(2)) dut0 (
    .alu_clk(clk), .alu_rst_n(rst_n), .start(start0),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .alu_a(a0), .alu_b(b0), .alu_c_in(cin0), .alu_sel(sel0),
    .alu_y(y0), .busy(busy0), .done(done0), .signature(sig0),
    .rd_addr(rd_addr), .rd_data(rd0)
  );

  alu_sweep_capture #(.DATA_W(8), .SEL_W(4), .SETTLE(1)) dut1 (
    .alu_clk(clk), .alu_rst_n(rst_n), .start(start1),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .alu_a(a1), .alu_b(b1), .alu_c_in(cin1), .alu_sel(sel1),
    .alu_y(y1), .busy(busy1), .done(done1), .signature(sig1),
    .rd_addr(rd_addr), .rd_data(rd1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
    op_a   = a;
    op_b   = b;
    op_cin = c;
  endtask

  task automatic readBank(input bit which, input logic [3:0] addr,
                          input logic [7:0] expected, input string tag);
    rd_addr = addr;
    @(negedge clk);
    checkOutput(tag, which ? {24'h0, rd1} : {24'h0, rd0}, {24'h0, expected});
  endtask

  // mode: 0 plain, 1 start-while-busy, 2 mid signature, 3 reset at sel 7, 4 read collision
  task automatic runSweep(input bit which, input int mode, output int busy_at, output int done_at);
    int cyc;
    busy_at = 0;
    done_at = 0;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    cyc = 1;
    while (cyc <= 200 && done_at == 0) begin
      if ((which ? busy1 : busy0) && busy_at == 0) busy_at = cyc;
      if (which ? done1 : done0) done_at = cyc;
      if (mode == 1 && cyc == 10) begin
        op_a   = 8'h55;
        start0 = 1'b1;
      end
      if (mode == 1 && cyc == 11) start0 = 1'b0;
      if (mode == 1 && cyc == 12) checkOutput("alu_a_ignored_start", {24'h0, a0}, 32'h03);
      if (mode == 2 && cyc == 25) checkOutput("sig_after_8", {24'h0, sig0}, 32'hFF);
      if (mode == 4 && cyc == 15) rd_addr = 4'd4;
      if (mode == 4 && cyc == 16) checkOutput("collision_old", {24'h0, rd0}, 32'h24);
      if (mode == 4 && cyc == 17) checkOutput("collision_new", {24'h0, rd0}, 32'h44);
      if (mode == 3 && cyc == 23) begin
        checkOutput("sel_before_reset", {28'h0, sel0}, 32'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_drive", {7'h0, cin0, a0, b0, 4'h0, sel0}, 32'h0);
        checkOutput("rst_status", {6'h0, busy0, done0, sig0, rd0, 8'h0}, 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        done_at = -1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    if (done_at == 0) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end
  endtask

  int busy_at, done_at;

  initial begin
    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("reset_drive", {7'h0, cin0, a0, b0, 4'h0, sel0}, 32'h0);
    checkOutput("reset_status", {6'h0, busy0, done0, sig0, rd0, 8'h0}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] full sweep with ignored start");
    applyStimulus(8'h03, 8'h0A, 1'b1);
    runSweep(1'b0, 1, busy_at, done_at);
    checkOutput("busy_first_cycle", busy_at, 32'd1);
    checkOutput("done_delay", done_at - busy_at, 32'd48);
    checkOutput("sig_a3", {24'h0, sig0}, 32'hFF);
    checkOutput("drive_at_done", {7'h0, cin0, a0, b0, 4'h0, sel0}, {7'h0, 1'b1, 8'h03, 8'h0A, 8'h0F});
    @(negedge clk);
    checkOutput("done_one_cycle", {30'h0, busy0, done0}, 32'h0);
    checkOutput("sig_hold", {24'h0, sig0}, 32'hFF);
    readBank(1'b0, 4'd0, 8'h03, "mem0");
    readBank(1'b0, 4'd5, 8'h06, "mem5");
    readBank(1'b0, 4'd15, 8'h0C, "mem15");

    $display("[TB] reset mid-sweep");
    applyStimulus(8'h11, 8'h00, 1'b0);
    runSweep(1'b0, 3, busy_at, done_at);
    readBank(1'b0, 4'd0, 8'h00, "rst_mem0");
    readBank(1'b0, 4'd5, 8'h00, "rst_mem5");
    readBank(1'b0, 4'd15, 8'h00, "rst_mem15");
    applyStimulus(8'h20, 8'h01, 1'b0);
    runSweep(1'b0, 0, busy_at, done_at);
    checkOutput("post_rst_done_delay", done_at - busy_at, 32'd48);
    @(negedge clk);
    readBank(1'b0, 4'd4, 8'h24, "post_rst_mem4");
    readBank(1'b0, 4'd9, 8'h29, "post_rst_mem9");

    $display("[TB] read collision");
    applyStimulus(8'h40, 8'h00, 1'b0);
    runSweep(1'b0, 4, busy_at, done_at);
    @(negedge clk);

    $display("[TB] constant stub signatures");
    force0 = 1'b1;
    cst0   = 8'h01;
    runSweep(1'b0, 2, busy_at, done_at);
    checkOutput("sig_const1", {24'h0, sig0}, 32'h00);
    readBank(1'b0, 4'd7, 8'h01, "const1_mem7");
    cst0 = 8'h00;
    runSweep(1'b0, 0, busy_at, done_at);
    checkOutput("sig_const0", {24'h0, sig0}, 32'h00);
    force0 = 1'b0;
    @(negedge clk);

    $display("[TB] SETTLE=1 instance");
    applyStimulus(8'h03, 8'h0A, 1'b1);
    runSweep(1'b1, 0, busy_at, done_at);
    checkOutput("s1_busy_first", busy_at, 32'd1);
    checkOutput("s1_done_delay", done_at - busy_at, 32'd32);
    checkOutput("s1_sig", {24'h0, sig1}, 32'hFF);
    @(negedge clk);
    readBank(1'b1, 4'd0, 8'h03, "s1_mem0");
    readBank(1'b1, 4'd5, 8'h06, "s1_mem5");
    readBank(1'b1, 4'd15, 8'h0C, "s1_mem15");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sweep_capture.md
# alu_sweep_capture

Hardware sweep controller and result collector for the 8-bit clocked ALU. On a start pulse it latches one operand set, drives the ALU's `alu_a`/`alu_b`/`alu_c_in`/`alu_sel` inputs through all 16 opcodes, and waits a fixed settle time per opcode. It then captures `alu_y` into a 16-entry result bank and folds each result into an 8-bit signature. It is the on-chip counterpart of the ALU stimulus: it drives the ALU inputs and consumes the ALU output, so results are readable by a host or compared against a golden signature.

## Interface
Parameters:
- `DATA_W`, default 8: operand and result width.
- `SEL_W`, default 4: opcode width; the sweep covers 2^SEL_W opcodes.
- `SETTLE`, default 2: cycles held per opcode before capture. Must be ≥ 1; covers the ALU's one-cycle registered output.

Ports:
- `alu_clk` in, 1: single clock, rising edge.
- `alu_rst_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: begin a sweep; sampled only in IDLE.
- `op_a` in, DATA_W: operand A, latched on accepted start.
- `op_b` in, DATA_W: operand B, latched on accepted start.
- `op_cin` in, 1: carry-in, latched on accepted start.
- `alu_a` out, DATA_W: drives the ALU's A input.
- `alu_b` out, DATA_W: drives the ALU's B input.
- `alu_c_in` out, 1: drives the ALU's carry-in.
- `alu_sel` out, SEL_W: drives the ALU's opcode select.
- `alu_y` in, DATA_W: ALU result.
- `busy` out, 1: high while a sweep is in progress.
- `done` out, 1: one-cycle pulse when the sweep completes.
- `signature` out, DATA_W: running result signature.
- `rd_addr` in, SEL_W: result bank read address.
- `rd_data` out, DATA_W: registered read data.

## Operation
States: IDLE, SETTLE, CAPTURE, FINISH. Encoding is in the package.

- **IDLE**
  - `start`=1: latch operands into `alu_a`/`alu_b`/`alu_c_in`, set `alu_sel`=0, clear `signature`, load the wait counter with SETTLE-1, go to SETTLE.
- **SETTLE**
  - Counter = 0: go to CAPTURE.
  - Otherwise: decrement the counter.
- **CAPTURE** (one cycle)
  - `mem[alu_sel] <= alu_y`.
  - `signature <= {signature[DATA_W-2:0], signature[DATA_W-1]} ^ alu_y` (rotate left by 1, then XOR).
  - `alu_sel` = max (15): go to FINISH and hold `alu_sel`.
  - Otherwise: increment `alu_sel`, reload the counter with SETTLE-1, go to SETTLE.
- **FINISH** (one cycle): `done`=1, then go to IDLE.

Signal rules:
- `busy`=1 in SETTLE and CAPTURE only.
- ALU drive outputs and `signature` hold their values after the sweep until the next accepted start.
- `start` is ignored outside IDLE. No restart or abort exists except reset.
- Read port: `rd_data <= mem[rd_addr]` every cycle, independent of state.
- Read and capture at the same address in the same cycle: `rd_data` returns the old value (read-before-write).

## Timing
- Reset values: `alu_a`=0, `alu_b`=0, `alu_c_in`=0, `alu_sel`=0, `busy`=0, `done`=0, `signature`=0, `rd_data`=0, all 16 bank entries 0, state IDLE.
- Reset asserted mid-sweep: all of the above is restored immediately (asynchronous). The sweep is lost, and a new start is needed after `alu_rst_n` deasserts.
- Start accepted at edge E0: ALU inputs are valid from E0 onward.
- Opcode k is held for SETTLE+1 cycles; its capture happens at the edge ending CAPTURE.
- `done` is high during cycle 16·(SETTLE+1)+1 after E0. With defaults this is cycle 49.
- `rd_data` latency: 1 cycle.

## Structure
- Shared package `alu_pkg`:
  - state enum (IDLE, SETTLE, CAPTURE, FINISH);
  - `ALU_DATA_W`=8, `ALU_SEL_W`=4, `ALU_NUM_OPS`=16.
- One sub-module: `alu_result_bank`, a 16×DATA_W register file with async-reset entries, one write port and a registered read port.
- The FSM, wait counter and signature live in the top level.

## Test plan
The bench uses an ALU stub with registered output `alu_y <= alu_a ^ {4'b0, alu_sel}`.

1. **Full sweep:** reset, `op_a`=3, `op_b`=10, `op_cin`=1, pulse `start`.
   - `busy` rises one cycle later.
   - `done` pulses exactly 48 cycles after the first busy cycle.
   - Reads return `mem[0]`=0x03, `mem[5]`=0x06, `mem[15]`=0x0C.
2. **Signature, constant stub output:**
   - `alu_y` held at 0x01: final `signature`=0x00, and `signature` after the 8th capture is 0xFF.
   - `alu_y` held at 0x00: final `signature`=0x00.
3. **Start ignored while busy:** pulse `start` with `op_a`=0x55 mid-sweep.
   - `alu_a` stays 0x03.
   - `done` timing is unchanged.
4. **Reset mid-sweep:** assert `alu_rst_n`=0 while `alu_sel`=7.
   - All outputs and bank entries read 0.
   - A new start completes normally.
5. **Read collision:** read address 4 on the capture cycle of opcode 4 → `rd_data` shows the old value; the next read shows the new value.
6. **Parameter SETTLE=1:** `done` arrives 32 cycles after the first busy cycle, and the bank contents match scenario 1.
